rx_token_decode: RTL and testbench

RX_TOKEN_DECODE -- requirements
Module: rx_token_decode

---
 rtl/rx_token_decode.sv | 165 ++++++++++++++++
 tb/tb_rx_token_decode.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rx_token_decode.sv
// Receive-side token decoder: tracks the NULL/escape sequence, pulses per-character
// events, and keeps the receive credit counter.
module rx_token_decode (
  input  logic       posedge_clk,
  input  logic       rx_resetn,
  input  logic       ready_control_p_r,
  input  logic       ready_data_p_r,
  input  logic [1:0] control_p_r,
  input  logic [7:0] data_p_r,
  input  logic       rx_error,
  input  logic       rx_fct_sent,
  output logic       rx_got_null,
  output logic       rx_got_fct,
  output logic       rx_got_nchar,
  output logic       rx_got_time_code,
  output logic       rx_buffer_write,
  output logic [8:0] rx_data_flag,
  output logic [7:0] rx_time_out,
  output logic [5:0] rx_credit,
  output logic       rx_esc_error,
  output logic       rx_credit_error
);

  localparam logic [1:0] C_FCT = 2'b00;
  localparam logic [1:0] C_EOP = 2'b01;
  localparam logic [1:0] C_EEP = 2'b10;
  localparam logic [1:0] C_ESC = 2'b11;
  localparam logic [6:0] C_CREDIT_MAX = 7'd56;

  typedef enum logic [1:0] {
    WAIT_NULL     = 2'd0,
    WAIT_NULL_ESC = 2'd1,
    RUN           = 2'd2,
    RUN_ESC       = 2'd3
  } state_t;

  state_t     r_state, w_state_next;
  logic       r_got_null, r_got_fct, r_got_nchar, r_got_time_code, r_buffer_write;
  logic [8:0] r_data_flag;
  logic [7:0] r_time_out;
  logic [5:0] r_credit;
  logic       r_esc_error, r_credit_error;

  logic       w_valid, w_is_ctrl;
  logic       w_got_null_next, w_got_fct_next, w_got_nchar_next, w_got_time_code_next;
  logic       w_buffer_write_next, w_esc_error_next, w_credit_error_next;
  logic [8:0] w_data_flag_next;
  logic [7:0] w_time_out_next;
  logic [5:0] w_credit_next;
  logic [6:0] w_credit_sum;

  // A strobe counts only when exactly one ready line is high and no error flags it.
  assign w_valid   = (ready_control_p_r ^ ready_data_p_r) & ~rx_error;
  assign w_is_ctrl = ready_control_p_r;

  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      r_state         <= WAIT_NULL;
      r_got_null      <= 1'b0;
      r_got_fct       <= 1'b0;
      r_got_nchar     <= 1'b0;
      r_got_time_code <= 1'b0;
      r_buffer_write  <= 1'b0;
      r_data_flag     <= 9'd0;
      r_time_out      <= 8'd0;
      r_credit        <= 6'd0;
      r_esc_error     <= 1'b0;
      r_credit_error  <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_got_null      <= w_got_null_next;
      r_got_fct       <= w_got_fct_next;
      r_got_nchar     <= w_got_nchar_next;
      r_got_time_code <= w_got_time_code_next;
      r_buffer_write  <= w_buffer_write_next;
      r_data_flag     <= w_data_flag_next;
      r_time_out      <= w_time_out_next;
      r_credit        <= w_credit_next;
      r_esc_error     <= w_esc_error_next;
      r_credit_error  <= w_credit_error_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_got_null_next      = r_got_null;
    w_got_fct_next       = 1'b0;
    w_got_nchar_next     = 1'b0;
    w_got_time_code_next = 1'b0;
    w_buffer_write_next  = 1'b0;
    w_data_flag_next     = r_data_flag;
    w_time_out_next      = r_time_out;
    w_esc_error_next     = r_esc_error;
    if (w_valid) begin
      case (r_state)
        WAIT_NULL: begin
          if (w_is_ctrl && control_p_r == C_ESC) w_state_next = WAIT_NULL_ESC;
        end
        WAIT_NULL_ESC: begin
          if (w_is_ctrl && control_p_r == C_FCT) begin
            w_got_null_next = 1'b1;
            w_state_next    = RUN;
          end else if (!(w_is_ctrl && control_p_r == C_ESC)) begin
            w_state_next = WAIT_NULL;
          end
        end
        RUN: begin
          if (!w_is_ctrl) begin
            w_got_nchar_next    = 1'b1;
            w_buffer_write_next = 1'b1;
            w_data_flag_next    = {1'b0, data_p_r};
          end else begin
            case (control_p_r)
              C_FCT: w_got_fct_next = 1'b1;
              C_ESC: w_state_next = RUN_ESC;
              default: begin
                w_got_nchar_next    = 1'b1;
                w_buffer_write_next = 1'b1;
                w_data_flag_next    = (control_p_r == C_EOP) ? 9'h100 : 9'h101;
              end
            endcase
          end
        end
        RUN_ESC: begin
          w_state_next = RUN;
          if (!w_is_ctrl) begin
            w_time_out_next      = data_p_r;
            w_got_time_code_next = 1'b1;
          end else if (control_p_r != C_FCT) begin
            w_esc_error_next = 1'b1;
          end
        end
        default: w_state_next = WAIT_NULL;
      endcase
    end
  end

  // Credit: +8 per FCT sent in any state, -1 per N-Char; an N-Char with no credit
  // and no coincident FCT is flagged but the counter stays pinned at zero.
  always_comb begin
    w_credit_next       = r_credit;
    w_credit_error_next = r_credit_error;
    w_credit_sum        = 7'd0;
    if (w_got_nchar_next && !rx_fct_sent && r_credit == 6'd0) begin
      w_credit_error_next = 1'b1;
      w_credit_next       = 6'd0;
    end else begin
      w_credit_sum  = {1'b0, r_credit} + (rx_fct_sent ? 7'd8 : 7'd0)
                      - (w_got_nchar_next ? 7'd1 : 7'd0);
      w_credit_next = (w_credit_sum > C_CREDIT_MAX) ? C_CREDIT_MAX[5:0] : w_credit_sum[5:0];
    end
  end

  assign rx_got_null      = r_got_null;
  assign rx_got_fct       = r_got_fct;
  assign rx_got_nchar     = r_got_nchar;
  assign rx_got_time_code = r_got_time_code;
  assign rx_buffer_write  = r_buffer_write;
  assign rx_data_flag     = r_data_flag;
  assign rx_time_out      = r_time_out;
  assign rx_credit        = r_credit;
  assign rx_esc_error     = r_esc_error;
  assign rx_credit_error  = r_credit_error;

endmodule

// File: tb/tb_rx_token_decode.sv
// Directed bench for rx_token_decode: a character-stream model checked every cycle,
// plus literal expectations at the interesting points of the sequence.
module tb_rx_token_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rc = 1'b0, rd = 1'b0, err = 1'b0, fct_sent = 1'b0;
  logic [1:0] code = 2'b00;
  logic [7:0] data = 8'h00;

  logic       got_null, got_fct, got_nchar, got_tc, buf_wr, esc_err, cred_err;
  logic [8:0] flag;
  logic [7:0] time_out;
  logic [5:0] credit;

  int checks = 0;
  int passed = 0;

  rx_token_decode dut (
    .posedge_clk       (clk),
    .rx_resetn         (rst_n),
    .ready_control_p_r (rc),
    .ready_data_p_r    (rd),
    .control_p_r       (code),
    .data_p_r          (data),
    .rx_error          (err),
    .rx_fct_sent       (fct_sent),
    .rx_got_null       (got_null),
    .rx_got_fct        (got_fct),
    .rx_got_nchar      (got_nchar),
    .rx_got_time_code  (got_tc),
    .rx_buffer_write   (buf_wr),
    .rx_data_flag      (flag),
    .rx_time_out       (time_out),
    .rx_credit         (credit),
    .rx_esc_error      (esc_err),
    .rx_credit_error   (cred_err)
  );

  always #5 clk = ~clk;

  // Model: "linked" once a NULL (ESC then FCT) has been seen; "esc" means the last
  // accepted character was an escape awaiting its partner.
  bit       m_linked = 0, m_esc = 0;
  bit       e_null = 0, e_fct = 0, e_nchar = 0, e_tc = 0, e_wr = 0, e_esc_err = 0, e_cred_err = 0;
  bit [8:0] e_flag = 0;
  bit [7:0] e_time = 0;
  int       e_credit = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_linked = 0; m_esc = 0;
      e_null = 0; e_fct = 0; e_nchar = 0; e_tc = 0; e_wr = 0;
      e_esc_err = 0; e_cred_err = 0; e_flag = 0; e_time = 0; e_credit = 0;
    end else begin
      bit is_data, is_fct, is_esc, nchar;
      int c;
      e_fct = 0; e_nchar = 0; e_tc = 0; e_wr = 0;
      nchar = 0;
      if ((rc != rd) && !err) begin
        is_data = rd;
        is_fct  = rc && code == 2'b00;
        is_esc  = rc && code == 2'b11;
        if (!m_linked) begin
          if (m_esc && is_fct) begin m_linked = 1; m_esc = 0; e_null = 1; end
          else m_esc = is_esc;
        end else if (m_esc) begin
          m_esc = 0;
          if (is_data) begin e_time = data; e_tc = 1; end
          else if (!is_fct) e_esc_err = 1;
        end else if (is_fct) e_fct = 1;
        else if (is_esc) m_esc = 1;
        else begin
          nchar = 1; e_nchar = 1; e_wr = 1;
          e_flag = is_data ? {1'b0, data} : (code == 2'b01 ? 9'h100 : 9'h101);
        end
      end
      c = e_credit + (fct_sent ? 8 : 0) - (nchar ? 1 : 0);
      if (c < 0) begin e_cred_err = 1; c = 0; end
      e_credit = (c > 56) ? 56 : c;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    chk("null", got_null, e_null);
    chk("fct", got_fct, e_fct);
    chk("nchar", got_nchar, e_nchar);
    chk("tc", got_tc, e_tc);
    chk("write", buf_wr, e_wr);
    chk("flag", flag, e_flag);
    chk("time", time_out, e_time);
    chk("credit", credit, e_credit);
    chk("esc_err", esc_err, e_esc_err);
    chk("cred_err", cred_err, e_cred_err);
  end

  // Drive one cycle starting just after a rising edge; returns just after the next
  // edge, when the registered response is visible.
  task automatic cyc(input logic c, input logic d, input logic [1:0] cd,
                     input logic [7:0] dt, input logic e, input logic f);
    rc = c; rd = d; code = cd; data = dt; err = e; fct_sent = f;
    @(posedge clk); #1;
    rc = 0; rd = 0; err = 0; fct_sent = 0;
    $display("tx ctrl=%0b data=%0b code=%0d byte=%02h err=%0b fct_sent=%0b -> wr=%0b flag=%03h credit=%0d",
             c, d, cd, dt, e, f, buf_wr, flag, credit);
  endtask

  task automatic ctl(input logic [1:0] cd); cyc(1, 0, cd, 8'h00, 0, 0); endtask
  task automatic dat(input logic [7:0] dt); cyc(0, 1, 2'b00, dt, 0, 0); endtask

  initial begin
    #1 rst_n = 0;
    #20;
    chk("reset_credit", credit, 0);
    chk("reset_null", got_null, 0);
    @(posedge clk); #1 rst_n = 1;

    dat(8'hAA);       chk("pre_null_wr", buf_wr, 0);
    ctl(2'b01);       chk("pre_null_eop_wr", buf_wr, 0);
    ctl(2'b11);
    ctl(2'b00);       chk("null_set", got_null, 1);
                      chk("null_no_fct", got_fct, 0);
    cyc(0, 0, 2'b00, 8'h00, 0, 1);
    chk("credit_8", credit, 8);
    for (int i = 1; i <= 8; i++) begin
      dat(8'(i));
      chk("data_flag", flag, i);
      chk("data_wr", buf_wr, 1);
      chk("data_credit", credit, 8 - i);
    end
    chk("no_cred_err", cred_err, 0);
    ctl(2'b10);
    chk("eep_flag", flag, 9'h101);
    chk("eep_wr", buf_wr, 1);
    chk("eep_cred_err", cred_err, 1);
    chk("eep_credit", credit, 0);

    ctl(2'b11);
    dat(8'h3F);       chk("tc_pulse", got_tc, 1);
                      chk("time_out", time_out, 8'h3F);
                      chk("tc_no_wr", buf_wr, 0);
    ctl(2'b11);
    ctl(2'b01);       chk("esc_err", esc_err, 1);
                      chk("esc_no_wr", buf_wr, 0);

    cyc(1, 0, 2'b00, 8'h00, 1, 0); chk("err_fct", got_fct, 0);
    cyc(1, 1, 2'b00, 8'h00, 0, 0); chk("both_fct", got_fct, 0);
                                   chk("both_wr", buf_wr, 0);
    ctl(2'b00);       chk("clean_fct", got_fct, 1);

    for (int i = 0; i < 7; i++) cyc(0, 0, 2'b00, 8'h00, 0, 1);
    chk("credit_sat", credit, 56);
    cyc(0, 0, 2'b00, 8'h00, 0, 1);
    chk("credit_sat2", credit, 56);
    dat(8'h10); dat(8'h11); dat(8'h12);
    chk("credit_53", credit, 53);
    cyc(0, 1, 2'b00, 8'h13, 0, 1);
    chk("credit_net", credit, 56);

    ctl(2'b11);
    #2 rst_n = 0;
    #1;
    chk("async_credit", credit, 0);
    chk("async_null", got_null, 0);
    chk("async_flag", flag, 0);
    @(posedge clk); #1 rst_n = 1;
    dat(8'h55);       chk("post_rst_tc", got_tc, 0);
                      chk("post_rst_wr", buf_wr, 0);
    ctl(2'b00);       chk("post_rst_null", got_null, 0);
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
